// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder datapath: loader FSM states and
// the default operand width used by the loader, adder and collector.
package serial_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;
endpackage

// File: rtl/piso_shift.sv
// Parallel-load, shift-right register; the LSB is the serial output.
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             lsb
);
  logic [WIDTH-1:0] q;

  // Load wins over shift; zero fill keeps the register clean after the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {1'b0, q[WIDTH-1:1]};
  end

  assign lsb = q[0];
endmodule

// File: rtl/serial_operand_loader.sv
// Captures two parallel operands, issues one carry-clear cycle, then streams
// both LSB-first to the bit-serial adder and pulses done after the last bit.
module serial_operand_loader
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             clr,
  output logic             done
);
  localparam int             NUM_LANES = 2;
  localparam logic [CW-1:0]  LAST      = CW'(WIDTH - 1);

  state_t                              state, state_nxt;
  logic [CW-1:0]                       cnt;
  logic                                accept, shift;
  logic [NUM_LANES-1:0][WIDTH-1:0]     par;
  logic [NUM_LANES-1:0]                lsb;

  assign accept = (state == ST_IDLE) && load;
  assign shift  = (state == ST_SHIFT);
  assign par[0] = a_in;
  assign par[1] = b_in;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    piso_shift #(.WIDTH(WIDTH)) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (shift),
      .d     (par[g]),
      .lsb   (lsb[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)     cnt <= '0;
      else if (shift) cnt <= cnt + 1'b1;
    end
  end

  // Outputs decode from state and registers only, never from inputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;
    done      = 1'b0;
    A         = 1'b0;
    B         = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (load) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr       = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        en = 1'b1;
        A  = lsb[0];
        B  = lsb[1];
        if (cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_operand_loader.sv
// Scoreboard bench: a timeline model predicts every output per cycle and
// queues each accepted operand pair; the monitor reassembles the serial words.
module tb_serial_operand_loader;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         ready, A, B, en, clr, done;

  int checks = 0;
  int errors = 0;

  serial_operand_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .a_in(a_in), .b_in(b_in),
    .ready(ready), .A(A), .B(B), .en(en), .clr(clr), .done(done)
  );

  always #5 clk = ~clk;

  // Reference timeline: -1 idle, 0 clear, 1..W bit (phase-1), W+1 done.
  int              phase = -1;
  logic [W-1:0]    ea, eb;
  logic [2*W-1:0]  sb_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase = -1;
      sb_q.delete();
    end else if (phase == -1) begin
      if (load) begin
        ea = a_in;
        eb = b_in;
        sb_q.push_back({a_in, b_in});
        phase = 0;
      end
    end else if (phase <= W) begin
      phase = phase + 1;
    end else begin
      phase = -1;
    end
  end

  // Monitor: per-cycle output check plus word reassembly compared on done.
  logic [W-1:0]   ga, gb;
  int             nbits = 0;
  logic [5:0]     exp_v, act_v;
  logic [2*W-1:0] exp_w;

  always @(negedge clk) begin
    exp_v = 6'b100000;
    if (phase == 0)                      exp_v = 6'b010000;
    else if (phase >= 1 && phase <= W)   exp_v = {4'b0010, ea[phase-1], eb[phase-1]};
    else if (phase == W + 1)             exp_v = 6'b000100;
    act_v = {ready, clr, en, done, A, B};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs t=%0t {ready,clr,en,done,A,B} got %b expected %b", $time, act_v, exp_v);
    end
    if (clr) nbits = 0;
    if (en && nbits < W) begin
      ga[nbits] = A;
      gb[nbits] = B;
      nbits++;
    end
    if (done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL word done with no pending transfer got %h_%h", ga, gb);
      end else begin
        exp_w = sb_q.pop_front();
        if ({ga, gb} !== exp_w || nbits != W) begin
          errors++;
          $display("FAIL word got A=%b B=%b bits=%0d expected A=%b B=%b bits=%0d",
                   ga, gb, nbits, exp_w[2*W-1:W], exp_w[W-1:0], W);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_load(input logic [W-1:0] a, input logic [W-1:0] b);
    load = 1'b1; a_in = a; b_in = b;
    step(1);
    load = 1'b0; a_in = $urandom; b_in = $urandom;
  endtask

  initial begin
    #1 rst = 1'b0;
    step(2);
    rst = 1'b1;

    // Idle after reset.
    step(10);

    // 3 + 5 and 15 + 15.
    pulse_load(4'b0011, 4'b0101);
    step(8);
    pulse_load(4'b1111, 4'b1111);
    step(8);

    // Load requests during a transfer are ignored.
    pulse_load(4'b1001, 4'b0110);
    step(2);
    load = 1'b1; a_in = 4'b1110; b_in = 4'b0111;
    step(3);
    load = 1'b0;
    step(4);

    // Back-to-back transfers with load held high.
    load = 1'b1; a_in = 4'b0001; b_in = 4'b0001;
    step(21);
    load = 1'b0;
    step(8);

    // Async reset after two shifted bits.
    pulse_load(4'b1010, 4'b1100);
    step(2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({ready, clr, en, done, A, B} !== 6'b100000) begin
      errors++;
      $display("FAIL async_reset got %b expected 100000", {ready, clr, en, done, A, B});
    end
    #2 rst = 1'b1;
    step(2);
    pulse_load(4'b0110, 4'b0011);
    step(8);

    // Randomized traffic; inputs churn every cycle.
    for (int i = 0; i < 300; i++) begin
      load = ($urandom_range(0, 2) == 0);
      a_in = $urandom;
      b_in = $urandom;
      step(1);
    end
    load = 1'b0;
    step(10);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending transfers got %0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
